// File: rtl/i2s_tx_master_if.sv
// Parallel sample-pair handshake between the DSP datapath and the I2S transmitter.
// The source drives the left/right pair and pvalid_in; the transmitter answers with pready_out.
interface i2s_tx_master_if #(
  parameter int PDATA_WIDTH = 32
) ();
  logic [PDATA_WIDTH-1:0] pldata_in;
  logic [PDATA_WIDTH-1:0] prdata_in;
  logic                   pvalid_in;
  logic                   pready_out;

  modport master (
    output pldata_in,
    output prdata_in,
    output pvalid_in,
    input  pready_out
  );

  modport slave (
    input  pldata_in,
    input  prdata_in,
    input  pvalid_in,
    output pready_out
  );
endinterface

// File: rtl/i2s_tx_master.sv
// I2S master transmitter: divides clk_in down to SCLK/LRCK and serializes buffered
// stereo pairs MSB-first with the standard one-bit delay after each LRCK transition.
module i2s_tx_master #(
  parameter int PDATA_WIDTH = 32,
  parameter int SLOT_WIDTH  = 32,
  parameter int SCLK_DIV    = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  i2s_tx_master_if.slave       s_if,
  output logic                 sclk_out,
  output logic                 lrck_out,
  output logic                 sdata_out,
  output logic                 underrun_out
);

  localparam int FRAME_W = 2 * SLOT_WIDTH;
  localparam int DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int POS_W   = $clog2(FRAME_W);

  logic [DIV_W-1:0]       r_div;
  logic [POS_W-1:0]       r_pos;
  logic                   r_sclk;
  logic                   r_lrck;
  logic                   r_sdata;
  logic                   r_underrun;
  logic [FRAME_W-1:0]     r_shift;
  logic                   r_buf_full;
  logic [PDATA_WIDTH-1:0] r_buf_l;
  logic [PDATA_WIDTH-1:0] r_buf_r;

  logic                   w_tc;
  logic                   w_fall;
  logic                   w_load;
  logic                   w_accept;
  logic [POS_W-1:0]       w_pos_next;
  logic [SLOT_WIDTH-1:0]  w_lslot;
  logic [SLOT_WIDTH-1:0]  w_rslot;
  logic [FRAME_W-1:0]     w_stream;

  assign w_tc       = (r_div == DIV_W'(SCLK_DIV - 1));
  assign w_fall     = w_tc && r_sclk;
  assign w_pos_next = (r_pos == POS_W'(FRAME_W - 1)) ? '0 : r_pos + POS_W'(1);
  assign w_load     = w_fall && (w_pos_next == POS_W'(1));
  assign w_accept   = s_if.pvalid_in && !r_buf_full;

  // Samples narrower than the slot are left-justified: MSB first, zero padding in the LSBs.
  assign w_lslot  = SLOT_WIDTH'(r_buf_l) << (SLOT_WIDTH - PDATA_WIDTH);
  assign w_rslot  = SLOT_WIDTH'(r_buf_r) << (SLOT_WIDTH - PDATA_WIDTH);
  assign w_stream = r_buf_full ? {w_lslot, w_rslot} : '0;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_div      <= '0;
      r_pos      <= '0;
      r_sclk     <= 1'b0;
      r_lrck     <= 1'b0;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
      r_shift    <= '0;
    end else begin
      r_div      <= w_tc ? '0 : r_div + DIV_W'(1);
      r_underrun <= w_load && !r_buf_full;
      if (w_tc) begin
        r_sclk <= ~r_sclk;
      end
      // LRCK and data move only with SCLK falling so the slave sees them stable on rising.
      if (w_fall) begin
        r_pos  <= w_pos_next;
        r_lrck <= (w_pos_next >= POS_W'(SLOT_WIDTH));
        if (w_load) begin
          r_sdata <= w_stream[FRAME_W-1];
          r_shift <= w_stream << 1;
        end else begin
          r_sdata <= r_shift[FRAME_W-1];
          r_shift <= r_shift << 1;
        end
      end
    end
  end

  // A load drains the buffer; an accept coinciding with an underrun load is kept for the next frame.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_buf_full <= 1'b0;
      r_buf_l    <= '0;
      r_buf_r    <= '0;
    end else if (w_load && r_buf_full) begin
      r_buf_full <= 1'b0;
    end else if (w_accept) begin
      r_buf_full <= 1'b1;
      r_buf_l    <= s_if.pldata_in;
      r_buf_r    <= s_if.prdata_in;
    end
  end

  assign s_if.pready_out = ~r_buf_full;
  assign sclk_out        = r_sclk;
  assign lrck_out        = r_lrck;
  assign sdata_out       = r_sdata;
  assign underrun_out    = r_underrun;

endmodule

// File: tb/tb_i2s_tx_master.sv
// Directed self-checking bench for i2s_tx_master; a 16-bit-sample instance shares clock and reset.
// Cycle numbers count clk_in rising edges since reset release, sampled 1 ns after each edge.
module tb_i2s_tx_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  i2s_tx_master_if #(.PDATA_WIDTH(32)) bus ();
  i2s_tx_master_if #(.PDATA_WIDTH(16)) bus16 ();

  logic sclk, lrck, sdata, underrun;
  logic sclk16, lrck16, sdata16, underrun16;

  i2s_tx_master #(.PDATA_WIDTH(32), .SLOT_WIDTH(32), .SCLK_DIV(2)) dut (
    .clk_in(clk), .rst_in(rst), .s_if(bus),
    .sclk_out(sclk), .lrck_out(lrck), .sdata_out(sdata), .underrun_out(underrun)
  );

  i2s_tx_master #(.PDATA_WIDTH(16), .SLOT_WIDTH(32), .SCLK_DIV(2)) dut16 (
    .clk_in(clk), .rst_in(rst), .s_if(bus16),
    .sclk_out(sclk16), .lrck_out(lrck16), .sdata_out(sdata16), .underrun_out(underrun16)
  );

  int          nCompared   = 0;
  int          nMismatched = 0;
  int          nUnderrun   = 0;
  int          cyc         = 0;
  logic        streamMode  = 1'b0;
  logic [31:0] cnt         = '0;

  always @(posedge clk) begin
    if (underrun) nUnderrun++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %h, required %h", tag, obs, exp);
    end
  endtask

  // Acceptances are judged from pready_out as seen before the edge.
  task automatic tick();
    logic acc, acc16;
    acc   = bus.pvalid_in && bus.pready_out;
    acc16 = bus16.pvalid_in && bus16.pready_out;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      if (streamMode) begin
        cnt++;
        bus.pldata_in = cnt;
        bus.prdata_in = ~cnt;
      end else begin
        bus.pvalid_in = 1'b0;
      end
    end
    if (acc16) bus16.pvalid_in = 1'b0;
  endtask

  task automatic goToCycle(input int n);
    while (cyc < n) tick();
  endtask

  task automatic applyReset();
    rst = 1'b1;
    bus.pvalid_in   = 1'b0;
    bus16.pvalid_in = 1'b0;
    streamMode      = 1'b0;
    #1;
    checkOutput("reset_outs", 64'({sclk, lrck, sdata, bus.pready_out, underrun}), 64'(5'b00010));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic applyStimulus(input logic [31:0] l, input logic [31:0] r);
    bus.pldata_in = l;
    bus.prdata_in = r;
    bus.pvalid_in = 1'b1;
  endtask

  // Stream bit i of frame f appears at position 1+i, sampled at the SCLK rising of that position.
  task automatic readStream(input int f, output logic [63:0] s, output logic [63:0] s16,
                            output logic [63:0] lr);
    for (int i = 0; i < 64; i++) begin
      goToCycle(4 * (64 * f + 1 + i) + 2);
      s[63-i]   = sdata;
      s16[63-i] = sdata16;
      lr[63-i]  = lrck;
    end
  endtask

  logic [63:0] st, st16, lr;
  logic [7:0]  sclkSeq;
  logic [4:0]  urSeq;
  logic [3:0]  lrSeq;
  logic [2:0]  urSeq2;
  logic        sdOr;
  int          base;

  initial begin
    bus.pldata_in   = '0;
    bus.prdata_in   = '0;
    bus.pvalid_in   = 1'b0;
    bus16.pldata_in = '0;
    bus16.prdata_in = '0;
    bus16.pvalid_in = 1'b0;
    #2;

    // Idle link: divider, LRCK period, silent data and periodic underrun.
    applyReset();
    checkOutput("reset_outs16", 64'({sclk16, lrck16, sdata16, bus16.pready_out, underrun16}), 64'(5'b00010));
    base = nUnderrun;
    sdOr = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      goToCycle(c);
      sdOr = sdOr | sdata;
      if (c <= 8) sclkSeq[8-c] = sclk;
      if (c <= 5) urSeq[5-c] = underrun;
      if (c >= 259 && c <= 261) urSeq2[261-c] = underrun;
      if (c == 127) lrSeq[3] = lrck;
      if (c == 128) lrSeq[2] = lrck;
      if (c == 255) lrSeq[1] = lrck;
      if (c == 256) lrSeq[0] = lrck;
    end
    checkOutput("idle_sclk", 64'(sclkSeq), 64'(8'b0110_0110));
    checkOutput("idle_underrun_first", 64'(urSeq), 64'(5'b00010));
    checkOutput("idle_underrun_second", 64'(urSeq2), 64'(3'b010));
    checkOutput("idle_lrck", 64'(lrSeq), 64'(4'b0110));
    checkOutput("idle_sdata", 64'(sdOr), 64'(1'b0));
    checkOutput("idle_underrun_count", 64'(nUnderrun - base), 64'(3));

    // Single pair before the first load, plus the 16-bit instance with left-justified padding.
    applyReset();
    applyStimulus(32'h8000_0001, 32'h7FFF_FFFF);
    bus16.pldata_in = 16'hA5A5;
    bus16.prdata_in = 16'h3C3C;
    bus16.pvalid_in = 1'b1;
    goToCycle(3);
    checkOutput("single_pready_held", 64'(bus.pready_out), 64'(1'b0));
    goToCycle(4);
    checkOutput("single_pready_back", 64'(bus.pready_out), 64'(1'b1));
    checkOutput("single_no_underrun", 64'(underrun), 64'(1'b0));
    readStream(0, st, st16, lr);
    checkOutput("single_stream", st, 64'h8000_0001_7FFF_FFFF);
    checkOutput("single_lrck", lr, 64'h0000_0001_FFFF_FFFE);
    checkOutput("narrow_stream", st16, 64'hA5A5_0000_3C3C_0000);

    // Back-to-back streaming with an incrementing counter.
    applyReset();
    cnt = '0;
    streamMode = 1'b1;
    applyStimulus(32'h0, 32'hFFFF_FFFF);
    base = nUnderrun;
    goToCycle(4);
    checkOutput("stream_pready_after_load", 64'(bus.pready_out), 64'(1'b1));
    goToCycle(5);
    checkOutput("stream_pready_after_accept", 64'(bus.pready_out), 64'(1'b0));
    for (int f = 0; f < 4; f++) begin
      readStream(f, st, st16, lr);
      checkOutput($sformatf("stream_frame%0d", f), st, {32'(f), ~32'(f)});
      if (f == 0) checkOutput("stream_pready_waiting", 64'(bus.pready_out), 64'(1'b0));
    end
    checkOutput("stream_underruns", 64'(nUnderrun - base), 64'(0));
    checkOutput("stream_accepts", 64'(cnt), 64'(5));
    streamMode = 1'b0;
    bus.pvalid_in = 1'b0;

    // Accept in the very cycle of an empty-buffer load.
    applyReset();
    goToCycle(3);
    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0);
    goToCycle(4);
    checkOutput("collide_underrun", 64'(underrun), 64'(1'b1));
    checkOutput("collide_pready", 64'(bus.pready_out), 64'(1'b0));
    readStream(0, st, st16, lr);
    checkOutput("collide_zero_frame", st, 64'h0);
    goToCycle(260);
    checkOutput("collide_pready_release", 64'(bus.pready_out), 64'(1'b1));
    readStream(1, st, st16, lr);
    checkOutput("collide_next_frame", st, 64'h1234_5678_9ABC_DEF0);

    // Reset at p=40 with a pair buffered: outputs clear at once and that pair is dropped.
    applyReset();
    applyStimulus(32'h1111_1111, 32'h2222_2222);
    goToCycle(4);
    applyStimulus(32'hDEAD_BEEF, 32'hCAFE_F00D);
    goToCycle(162);
    checkOutput("midreset_pre_state", 64'({lrck, bus.pready_out}), 64'(2'b10));
    rst = 1'b1;
    bus.pvalid_in = 1'b0;
    #1;
    checkOutput("midreset_outs", 64'({sclk, lrck, sdata, bus.pready_out, underrun}), 64'(5'b00010));
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    goToCycle(4);
    checkOutput("midreset_underrun", 64'(underrun), 64'(1'b1));
    readStream(0, st, st16, lr);
    checkOutput("midreset_frame0", st, 64'h0);
    readStream(1, st, st16, lr);
    checkOutput("midreset_frame1", st, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
